dual_port_ram_ctrl: RTL and testbench
=====================================

Name: dual_port_ram_ctrl

Overview:
- Parametrised true dual-port synchronous RAM. It is the successor to the fixed 1024x18 dual-port RAM.
- Adds configurable width and depth, per-port enables, selectable read-during-write mode, optional output pipeline register, deterministic cross-port collision handling and a post-reset memory-clear sweep.
- Used as the shared buffer between two independent requesters in the same clock domain.

Parameters:
- DATA_W, 18, word width in bits.
- ADDR_W, 10, address width; depth = 2**ADDR_W.
- RDW_MODE, 0, same-port read-during-write: 0 = READ_FIRST (q shows old word), 1 = WRITE_FIRST (q shows new word).
- OUT_REG, 0, 1 adds an output register stage, making read latency 2.
- INIT_ON_RESET, 1, 1 clears the whole array after reset; 0 skips the sweep.
- INIT_VAL, 0, word written to every location during the sweep.

Ports:
- clk, in, 1, sole clock; all logic on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- enA, in, 1, port A access request (read, or write if weA).
- weA, in, 1, port A write enable; qualified by enA.
- addrA, in, ADDR_W, port A address.
- dataA, in, DATA_W, port A write data.
- enB, in, 1, port B access request.
- weB, in, 1, port B write enable; qualified by enB.
- addrB, in, ADDR_W, port B address.
- dataB, in, DATA_W, port B write data.
- qA, out, DATA_W, port A read data.
- qB, out, DATA_W, port B read data.
- validA, out, 1, qA updated this cycle by an enabled access.
- validB, out, 1, qB updated this cycle by an enabled access.
- ready, out, 1, high once the sweep is done; accesses accepted only while high.
- collision, out, 1, one-cycle pulse aligned with validA/validB for a cross-port conflict.

Behaviour:
- Reset (async assert): qA = qB = 0, validA = validB = 0, ready = 0, collision = 0, pipeline stages cleared, FSM to INIT (or READY if INIT_ON_RESET = 0), sweep counter = 0. Array contents are not touched by rst itself.
- FSM INIT:
  - Each cycle writes INIT_VAL to array[cnt], then cnt++.
  - After writing address 2**ADDR_W-1, moves to READY; ready goes high on the following cycle.
  - Sweep takes exactly 2**ADDR_W cycles after rst deassertion.
  - enA, enB, weA and weB are ignored; validA/validB stay 0.
- FSM READY: stays in READY until rst. Sampled with ready = 1, requests are accepted.
- Latency: an access accepted at edge N drives qX and validX at edge N+1 (OUT_REG = 0) or N+2 (OUT_REG = 1).
  - validX is a one-cycle pulse per accepted access.
  - qX holds its last value when there is no access.
- Write on port X: qX returns the old word (RDW_MODE = 0) or dataX (RDW_MODE = 1).
- Cross-port collision: enA and enB both set, addrA == addrB, and at least one write.
  - Both write: port A data is stored; port B write is dropped; collision pulses.
  - One writes, other reads: the reader gets the OLD word regardless of RDW_MODE; the write completes; collision pulses.
  - Both read: no collision.
- Collision pulse uses the same latency as validX.
- Reset mid-operation:
  - In-flight reads are discarded with no valid pulse.
  - A sweep in progress restarts from address 0.
  - In READY with INIT_ON_RESET = 1, the full sweep is re-run.
- Address width is exact; no wrap logic is needed. The sweep counter is ADDR_W+1 bits so it can detect the terminal count.

Decomposition:
- Package dual_port_ram_pkg holds:
  - RDW_READ_FIRST / RDW_WRITE_FIRST constants.
  - FSM state encoding ST_INIT, ST_READY.
- Sub-module dp_ram_core:
  - Bare two-port synchronous array with per-port en/we/addr/data/q and RDW_MODE.
  - The wrapper muxes the sweep writer onto port A, masks port B writes on collision, forces old-data on cross-port reads, and implements the output register and valid/collision pipeline.

Test Plan:
- Defaults; hold rst 3 cycles, release → ready = 0 for 1024 cycles, then 1. Read A addr 0x3FF → qA = 0x00000, validA one cycle later.
- Write B addr 0x080 data 0x0C9E5; next cycle read A addr 0x080 → qA = 0x0C9E5, validA = 1, collision = 0.
- RDW_MODE = 1: write A addr 0x020 data 0x2E995 → qA = 0x2E995 next cycle. RDW_MODE = 0, same write over prior 0x00000 → qA = 0x00000.
- Same cycle: A writes 0x0A99D and B writes 0x24DF1, both to addr 0x08C → collision pulses once; later read of 0x08C returns 0x0A99D.
- Same cycle: A writes 0x2E995 to 0x0AC while B reads 0x0AC holding 0x0C9E5 → qB = 0x0C9E5, collision = 1; next read of 0x0AC → 0x2E995.
- Assert rst 500 cycles into the sweep → outputs zero immediately; after release, ready rises exactly 1024 cycles later. Repeat the scenario-2 access with OUT_REG = 1 → qA and validA appear at N+2.

Source files
------------

// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg: shared constants for the parametrised dual-port RAM controller
package dual_port_ram_pkg;
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
endpackage

// File: rtl/dp_ram_core.sv
// dp_ram_core: bare two-port synchronous array; we writes, en gates the read register
module dp_ram_core
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_W   = 18,
    parameter int ADDR_W   = 10,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enA,
    input  logic              weA,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] qA,
    input  logic              enB,
    input  logic              weB,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] dataB,
    output logic [DATA_W-1:0] qB
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (weA) mem[addrA] <= dataA;
        if (weB) mem[addrB] <= dataB;
    end

    // Reads sample the pre-edge array, so cross-port reads always see the old word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qA <= '0;
            qB <= '0;
        end else begin
            if (enA) qA <= (RDW_MODE == RDW_WRITE_FIRST && weA) ? dataA : mem[addrA];
            if (enB) qB <= (RDW_MODE == RDW_WRITE_FIRST && weB) ? dataB : mem[addrB];
        end
    end
endmodule

// File: rtl/dual_port_ram_ctrl.sv
// dual_port_ram_ctrl: true dual-port RAM wrapper with clear sweep, collision
// handling, optional output register and valid/collision pipeline
module dual_port_ram_ctrl
    import dual_port_ram_pkg::*;
#(
    parameter int                DATA_W        = 18,
    parameter int                ADDR_W        = 10,
    parameter int                RDW_MODE      = RDW_READ_FIRST,
    parameter int                OUT_REG       = 0,
    parameter int                INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VAL      = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enA,
    input  logic              weA,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [DATA_W-1:0] dataA,
    input  logic              enB,
    input  logic              weB,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] dataB,
    output logic [DATA_W-1:0] qA,
    output logic [DATA_W-1:0] qB,
    output logic              validA,
    output logic              validB,
    output logic              ready,
    output logic              collision
);
    logic [0:0]        state;
    logic [ADDR_W:0]   cnt, cntNext;
    logic              accA, accB, sameAddr, coll, coreWeA, coreWeB;
    logic              vA1, vB1, c1;
    logic [ADDR_W-1:0] coreAddrA;
    logic [DATA_W-1:0] coreDataA, rawA, rawB;

    assign ready     = state == ST_READY;
    assign cntNext   = cnt + 1'b1;
    assign accA      = ready & enA;
    assign accB      = ready & enB;
    assign sameAddr  = addrA == addrB;
    assign coll      = accA & accB & sameAddr & (weA | weB);
    // The sweep owns port A until ready; on a double write port A wins
    assign coreWeA   = ~ready | (accA & weA);
    assign coreAddrA = ready ? addrA : cnt[ADDR_W-1:0];
    assign coreDataA = ready ? dataA : INIT_VAL;
    assign coreWeB   = accB & weB & ~(accA & weA & sameAddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            cnt   <= '0;
            vA1   <= 1'b0;
            vB1   <= 1'b0;
            c1    <= 1'b0;
        end else begin
            if (!ready) begin
                cnt <= cntNext;
                if (cntNext[ADDR_W]) state <= ST_READY;
            end
            vA1 <= accA;
            vB1 <= accB;
            c1  <= coll;
        end
    end

    dp_ram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE)) uCore (
        .clk(clk), .rst(rst),
        .enA(accA), .weA(coreWeA), .addrA(coreAddrA), .dataA(coreDataA), .qA(rawA),
        .enB(accB), .weB(coreWeB), .addrB(addrB), .dataB(dataB), .qB(rawB)
    );

    if (OUT_REG != 0) begin : gOutReg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                qA        <= '0;
                qB        <= '0;
                validA    <= 1'b0;
                validB    <= 1'b0;
                collision <= 1'b0;
            end else begin
                if (vA1) qA <= rawA;
                if (vB1) qB <= rawB;
                validA    <= vA1;
                validB    <= vB1;
                collision <= c1;
            end
        end
    end else begin : gDirect
        assign qA        = rawA;
        assign qB        = rawB;
        assign validA    = vA1;
        assign validB    = vB1;
        assign collision = c1;
    end
endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// tb_dual_port_ram_ctrl: scoreboard bench driving three configurations
// (READ_FIRST, WRITE_FIRST, READ_FIRST+OUT_REG) with shared directed stimulus
module tb_dual_port_ram_ctrl;
    typedef struct {
        logic [17:0] q;
        logic        coll;
        int          cyc;
    } expT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enA = 1'b0, weA = 1'b0, enB = 1'b0, weB = 1'b0;
    logic [9:0]  addrA = '0, addrB = '0;
    logic [17:0] dataA = '0, dataB = '0;
    logic [17:0] qA [3];
    logic [17:0] qB [3];
    logic [2:0]  validA, validB, ready, collision;
    int          cyc = 0;
    int          nChecks = 0;
    int          nFail = 0;
    expT         sb [6][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dual_port_ram_ctrl #(.RDW_MODE(0), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .enA(enA), .weA(weA), .addrA(addrA), .dataA(dataA),
        .enB(enB), .weB(weB), .addrB(addrB), .dataB(dataB), .qA(qA[0]), .qB(qB[0]),
        .validA(validA[0]), .validB(validB[0]), .ready(ready[0]), .collision(collision[0]));
    dual_port_ram_ctrl #(.RDW_MODE(1), .OUT_REG(0)) dut1 (
        .clk(clk), .rst(rst), .enA(enA), .weA(weA), .addrA(addrA), .dataA(dataA),
        .enB(enB), .weB(weB), .addrB(addrB), .dataB(dataB), .qA(qA[1]), .qB(qB[1]),
        .validA(validA[1]), .validB(validB[1]), .ready(ready[1]), .collision(collision[1]));
    dual_port_ram_ctrl #(.RDW_MODE(0), .OUT_REG(1)) dut2 (
        .clk(clk), .rst(rst), .enA(enA), .weA(weA), .addrA(addrA), .dataA(dataA),
        .enB(enB), .weB(weB), .addrB(addrB), .dataB(dataB), .qA(qA[2]), .qB(qB[2]),
        .validA(validA[2]), .validB(validB[2]), .ready(ready[2]), .collision(collision[2]));

    // Monitor: every valid pulse pops one expectation (value, collision, cycle)
    always @(negedge clk) begin
        logic        v;
        logic [17:0] q;
        expT         e;
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++) begin
                v = (p == 1) ? validB[d] : validA[d];
                q = (p == 1) ? qB[d] : qA[d];
                if (v) begin
                    nChecks++;
                    if (sb[d*2+p].size() == 0) begin
                        nFail++;
                        $display("FAIL unexpected_valid dut%0d port%0d got q=%h cyc=%0d", d, p, q, cyc);
                    end else begin
                        e = sb[d*2+p].pop_front();
                        if (q !== e.q || collision[d] !== e.coll || cyc != e.cyc) begin
                            nFail++;
                            $display("FAIL read dut%0d port%0d got q=%h coll=%b cyc=%0d want q=%h coll=%b cyc=%0d",
                                     d, p, q, collision[d], cyc, e.q, e.coll, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic checkZero(input string name);
        for (int d = 0; d < 3; d++)
            check($sformatf("%s_dut%0d", name, d),
                  {qA[d], qB[d], validA[d], validB[d], ready[d], collision[d]}, 64'd0);
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[0] && n < 2000);
        check({name, "_cycles"}, n, 1024);
        check({name, "_all"}, ready, 3'b111);
    endtask

    // Expectation for port p: READ_FIRST duts get qRf, the WRITE_FIRST dut gets qWf
    task automatic expQ(input int p, input logic [17:0] qRf, input logic [17:0] qWf, input logic c);
        sb[0*2+p].push_back('{qRf, c, cyc + 1});
        sb[1*2+p].push_back('{qWf, c, cyc + 1});
        sb[2*2+p].push_back('{qRf, c, cyc + 2});
    endtask

    task automatic acc(input logic ea, input logic wa, input logic [9:0] aa, input logic [17:0] da,
                       input logic eb, input logic wb, input logic [9:0] ab, input logic [17:0] db);
        enA = ea; weA = wa; addrA = aa; dataA = da;
        enB = eb; weB = wb; addrB = ab; dataB = db;
    endtask

    task automatic idle();
        enA = 1'b0; weA = 1'b0; enB = 1'b0; weB = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        idle();
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size() + sb[5].size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, "_drained"}, sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size() + sb[5].size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkZero("reset");
        rst = 1'b0;
        waitReady("sweep1");
        acc(1, 0, 10'h3FF, 0, 0, 0, 0, 0);
        expQ(0, 18'h00000, 18'h00000, 0);
        @(negedge clk);
        acc(0, 0, 0, 0, 1, 1, 10'h080, 18'h0C9E5);
        expQ(1, 18'h00000, 18'h0C9E5, 0);
        @(negedge clk);
        acc(1, 0, 10'h080, 0, 0, 0, 0, 0);
        expQ(0, 18'h0C9E5, 18'h0C9E5, 0);
        @(negedge clk);
        acc(1, 1, 10'h020, 18'h2E995, 0, 0, 0, 0);
        expQ(0, 18'h00000, 18'h2E995, 0);
        @(negedge clk);
        acc(1, 1, 10'h08C, 18'h0A99D, 1, 1, 10'h08C, 18'h24DF1);
        expQ(0, 18'h00000, 18'h0A99D, 1);
        expQ(1, 18'h00000, 18'h00000, 1);
        @(negedge clk);
        acc(1, 0, 10'h08C, 0, 0, 0, 0, 0);
        expQ(0, 18'h0A99D, 18'h0A99D, 0);
        @(negedge clk);
        acc(0, 0, 0, 0, 1, 1, 10'h0AC, 18'h0C9E5);
        expQ(1, 18'h00000, 18'h0C9E5, 0);
        @(negedge clk);
        acc(1, 1, 10'h0AC, 18'h2E995, 1, 0, 10'h0AC, 0);
        expQ(0, 18'h0C9E5, 18'h2E995, 1);
        expQ(1, 18'h0C9E5, 18'h0C9E5, 1);
        @(negedge clk);
        acc(1, 0, 10'h0AC, 0, 1, 0, 10'h08C, 0);
        expQ(0, 18'h2E995, 18'h2E995, 0);
        expQ(1, 18'h0A99D, 18'h0A99D, 0);
        @(negedge clk);
        drain("phase1");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        check("mid_sweep_not_ready", ready, 3'b000);
        rst = 1'b1;
        #1;
        checkZero("mid_sweep_rst");
        @(negedge clk);
        rst = 1'b0;
        waitReady("sweep2");
        acc(0, 0, 0, 0, 1, 1, 10'h080, 18'h0C9E5);
        expQ(1, 18'h00000, 18'h0C9E5, 0);
        @(negedge clk);
        acc(1, 0, 10'h080, 0, 0, 0, 0, 0);
        expQ(0, 18'h0C9E5, 18'h0C9E5, 0);
        @(negedge clk);
        acc(1, 0, 10'h08C, 0, 0, 0, 0, 0);
        expQ(0, 18'h00000, 18'h00000, 0);
        @(negedge clk);
        drain("phase2");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
